// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS control path.
// Holds opcode/funct encodings, ALU op-codes (shared with the ALU),
// datapath select encodings and the controller state enumeration.
package mips_defs;

    localparam int ALUOP_WIDTH = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDU = 5'b00001;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUBU = 5'b00010;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 5'b00011;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 5'b00100;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = 5'b00101;
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI  = 5'b00110;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP
    } state_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU op-code decoder.
//   opcode, funct : instruction fields from the IR
//   aluop         : ALU operation for the execute step (addu when unused)
//   legal         : instruction is a supported encoding
module alu_dec
    import mips_defs::*;
(
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    output logic [ALUOP_WIDTH-1:0] aluop,
    output logic                   legal
);

    always_comb begin
        aluop = ALU_ADDU;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  aluop = ALU_ADD;
                    FN_ADDU: aluop = ALU_ADDU;
                    FN_SUBU: aluop = ALU_SUBU;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_SLT:  aluop = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI:  aluop = ALU_ADD;
            OP_ADDIU: aluop = ALU_ADDU;
            OP_ORI:   aluop = ALU_OR;
            OP_LUI:   aluop = ALU_LUI;
            OP_LW, OP_SW: aluop = ALU_ADDU;
            OP_BEQ:   aluop = ALU_SUBU;
            OP_J:     aluop = ALU_ADDU;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle Moore control unit: sequences fetch/decode/execute/memory/
// write-back and drives all datapath enables, mux selects and aluop.
//   clk, rst           : clock, async active-high reset
//   opcode, funct      : IR fields, stable from DECODE to retire
//   zero, mem_ready    : ALU zero flag, memory completion handshake
//   pc_wr .. pc_src    : datapath enables and selects
//   retire, illegal    : per-instruction completion / bad-encoding pulses
//
// state    | meaning
// IDLE     | post-reset, drives defaults only
// FETCH    | read instruction at PC, PC+4 written on mem_ready
// DECODE   | precompute branch target, dispatch on opcode
// EXEC_R   | A op B for R-type
// EXEC_I   | A op imm for I-type ALU ops
// MEM_ADDR | A + sext(imm) load/store address
// MEM_RD   | data read at ALUOut
// MEM_WR   | data write at ALUOut, retires on mem_ready
// WB_R     | write rd
// WB_I     | write rt from ALUOut
// WB_MEM   | write rt from MDR
// BRANCH   | compare A-B, take precomputed target on zero
// JUMP     | load jump target
module mc_ctrl
    import mips_defs::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               reg_wr,
    output logic               iord,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] aluop,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic [1:0]         pc_src,
    output logic               retire,
    output logic               illegal
);

    state_t state, next_state;
    logic [ALUOP_WIDTH-1:0] dec_aluop;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic                   dec_legal;

    alu_dec u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .aluop  (dec_aluop),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    assign aluop = ALUOP_W'(alu_op);

    always_comb begin
        next_state = state;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_op     = 1'b0;
        alu_op     = ALU_ADDU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PCSRC_ALU;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_wr     = mem_ready;
                ir_wr     = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
                ext_op    = 1'b1;
                if (!dec_legal) begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:                         next_state = S_EXEC_R;
                        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: next_state = S_EXEC_I;
                        OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
                        OP_BEQ:                           next_state = S_BRANCH;
                        OP_J:                             next_state = S_JUMP;
                        default: begin
                            illegal    = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_op     = dec_aluop;
                next_state = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_op     = (opcode == OP_ADDI) || (opcode == OP_ADDIU);
                alu_op     = dec_aluop;
                next_state = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_op     = 1'b1;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                retire = mem_ready;
                if (mem_ready) next_state = S_FETCH;
            end
            S_WB_R: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_I: begin
                reg_wr     = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_op     = ALU_SUBU;
                pc_src     = PCSRC_ALUOUT;
                pc_wr      = zero;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_wr      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule
